arith_compare_sequencer: RTL and testbench

Sequential command front-end for the N-bit add/subtract/compare datapath. Accepts one operand-pair command at a time over a valid/ready handshake and drives the combinational datapath. Registers the result and the equal/less/greater flags into a response held under its own valid/ready handshake. Adds a multi-cycle absolute-difference command built from a compare pass followed by an ordered subtract pass.

---
 rtl/arith_pkg.sv | 25 ++
 rtl/arith_compare_core.sv | 44 ++++
 rtl/arith_compare_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_arith_compare_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arith_pkg
// Description : Shared definitions for the add/sub/compare sequencer: command
//               op encodings and the sequencer FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package arith_pkg;

  // Command op encodings carried on cmd_op.
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_ABS = 2'b11;

  // Sequencer FSM states, explicitly 2 bits wide.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    ORDER = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/arith_compare_core.sv
`default_nettype none
// ============================================================================
// Module      : arith_compare_core
// Description : Purely combinational N-bit unsigned add/subtract/compare
//               datapath. Result follows the op; the three compare flags are
//               always produced and qualified by the caller.
// Ports       : a_i, b_i   - operands (N bits)
//               op_i       - 00 add, 01 sub, 10 compare, 11 subtract
//               result_o   - truncated N-bit result (0 for compare)
//               equal_o    - a_i == b_i
//               less_o     - a_i <  b_i (unsigned)
//               greater_o  - a_i >  b_i (unsigned)
// Revision    : 1.0 - initial release
// ============================================================================
module arith_compare_core
  import arith_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [1:0]   op_i,
  output logic [N-1:0] result_o,
  output logic         equal_o,
  output logic         less_o,
  output logic         greater_o
);

  // Op 11 maps onto the subtractor; the sequencer orders the operands first.
  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:         result_o = a_i + b_i;
      OP_SUB, OP_ABS: result_o = a_i - b_i;
      default:        result_o = '0;
    endcase
  end

  assign equal_o   = (a_i == b_i);
  assign less_o    = (a_i <  b_i);
  assign greater_o = (a_i >  b_i);

endmodule
`default_nettype wire

// File: rtl/arith_compare_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : arith_compare_sequencer
// Description : Command front-end for the add/sub/compare datapath. Accepts
//               one command over a valid/ready handshake, runs it through the
//               datapath (two passes for absolute difference: compare, then
//               ordered subtract) and holds the result in a registered
//               response under its own valid/ready handshake.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               cmd_valid/cmd_ready      - command handshake
//               cmd_a, cmd_b, cmd_op     - operands and op code
//               rsp_valid/rsp_ready      - response handshake
//               rsp_result               - N-bit result
//               rsp_equal/less/greater   - compare flags (ops 10, 11)
//               busy                     - high whenever the FSM is not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module arith_compare_sequencer
  import arith_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  input  logic [1:0]   cmd_op,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_equal,
  output logic         rsp_less,
  output logic         rsp_greater,
  output logic         busy
);

  state_e       state_q, state_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [1:0]   op_q, op_d;
  logic         cmd_ready_q;
  logic         rsp_valid_q;
  logic [N-1:0] result_q, result_d;
  logic         equal_q, equal_d;
  logic         less_q, less_d;
  logic         greater_q, greater_d;

  logic [1:0]   core_op;
  logic [N-1:0] core_result;
  logic         core_equal;
  logic         core_less;
  logic         core_greater;

  logic         cmd_fire;

  assign cmd_fire = cmd_valid && cmd_ready_q;

  arith_compare_core #(
    .N (N)
  ) u_core (
    .a_i       (a_q),
    .b_i       (b_q),
    .op_i      (core_op),
    .result_o  (core_result),
    .equal_o   (core_equal),
    .less_o    (core_less),
    .greater_o (core_greater)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_fire) state_d = EXEC;
      EXEC:    state_d = (op_q == OP_ABS) ? ORDER : RESP;
      ORDER:   state_d = RESP;
      // A new command arriving with rsp_ready is left for the next IDLE cycle.
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath-control logic
  // --------------------------------------------------------------------------
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    result_d  = result_q;
    equal_d   = equal_q;
    less_d    = less_q;
    greater_d = greater_q;
    core_op   = op_q;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          a_d  = cmd_a;
          b_d  = cmd_b;
          op_d = cmd_op;
        end
      end
      EXEC: begin
        case (op_q)
          OP_ADD, OP_SUB: begin
            result_d  = core_result;
            equal_d   = 1'b0;
            less_d    = 1'b0;
            greater_d = 1'b0;
          end
          OP_CMP: begin
            result_d  = '0;
            equal_d   = core_equal;
            less_d    = core_less;
            greater_d = core_greater;
          end
          default: begin
            // Absolute difference, first pass: record the ordering and put
            // the larger operand in A so the second pass cannot wrap.
            equal_d   = core_equal;
            less_d    = core_less;
            greater_d = core_greater;
            if (core_less) begin
              a_d = b_q;
              b_d = a_q;
            end
          end
        endcase
      end
      ORDER: begin
        core_op  = OP_SUB;
        result_d = core_result;
      end
      default: begin
        // RESP: response registers are frozen while rsp_valid is high.
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand, handshake and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      result_q    <= '0;
      equal_q     <= 1'b0;
      less_q      <= 1'b0;
      greater_q   <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      cmd_ready_q <= (state_d == IDLE);
      rsp_valid_q <= (state_d == RESP);
      result_q    <= result_d;
      equal_q     <= equal_d;
      less_q      <= less_d;
      greater_q   <= greater_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = result_q;
  assign rsp_equal   = equal_q;
  assign rsp_less    = less_q;
  assign rsp_greater = greater_q;
  assign busy        = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_arith_compare_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_arith_compare_sequencer
// Description : Directed self-checking bench for arith_compare_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arith_compare_sequencer;

  localparam int unsigned N = 8;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [N-1:0] cmd_a;
  logic [N-1:0] cmd_b;
  logic [1:0]   cmd_op;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_result;
  logic         rsp_equal;
  logic         rsp_less;
  logic         rsp_greater;
  logic         busy;

  int n_total;
  int n_pass;

  arith_compare_sequencer #(
    .N (N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_op      (cmd_op),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_equal   (rsp_equal),
    .rsp_less    (rsp_less),
    .rsp_greater (rsp_greater),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [2:0] flags();
    return {rsp_equal, rsp_less, rsp_greater};
  endfunction

  // Issue one command with rsp_ready high and check the full timeline:
  // accept at edge 0, response visible after edge 1 (sampled at edge 2) for
  // ops 00-10, one cycle later for op 11, handshake back to IDLE.
  task automatic run_cmd(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic [7:0] exp_res,
                         input logic [2:0] exp_flags);
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    step();                                   // edge 0: accept
    cmd_valid = 1'b0;
    chk({tag, "_ready_low"}, 32'(cmd_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_valid_e0"}, 32'(rsp_valid), 32'd0);
    if (op == 2'b11) begin
      step();                                 // edge 1: EXEC -> ORDER
      chk({tag, "_valid_e1"}, 32'(rsp_valid), 32'd0);
    end
    step();                                   // RESP entered
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_result"}, 32'(rsp_result), 32'(exp_res));
    chk({tag, "_flags"}, 32'(flags()), 32'(exp_flags));
    step();                                   // handshake edge
    chk({tag, "_valid_clr"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    n_total   = 0;
    n_pass    = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_op    = 2'b00;
    rsp_ready = 1'b0;

    // Reset held for 3 cycles.
    step(); step(); step();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_result", 32'(rsp_result), 32'd0);
    chk("rst_flags", 32'(flags()), 32'd0);
    rst = 1'b0;
    step();

    // Flags are {equal, less, greater}.
    run_cmd("add",      8'h06, 8'h05, 2'b00, 8'h0B, 3'b000);
    run_cmd("add_wrap", 8'hFF, 8'h01, 2'b00, 8'h00, 3'b000);
    run_cmd("sub_wrap", 8'h05, 8'h06, 2'b01, 8'hFF, 3'b000);
    run_cmd("cmp_gt",   8'h06, 8'h05, 2'b10, 8'h00, 3'b001);
    run_cmd("abs_lt",   8'h05, 8'h0C, 2'b11, 8'h07, 3'b010);
    run_cmd("abs_gt",   8'h0C, 8'h05, 2'b11, 8'h07, 3'b001);
    run_cmd("abs_eq",   8'h33, 8'h33, 2'b11, 8'h00, 3'b100);
    // Compare after an add: result must be forced to zero.
    run_cmd("add_pre",  8'h10, 8'h01, 2'b00, 8'h11, 3'b000);
    run_cmd("cmp_eq",   8'h44, 8'h44, 2'b10, 8'h00, 3'b100);

    // Backpressure: compare 0x03 vs 0x09 with rsp_ready low.
    cmd_a = 8'h03; cmd_b = 8'h09; cmd_op = 2'b10;
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    step();                                   // accept
    cmd_a = 8'h10; cmd_b = 8'h20; cmd_op = 2'b00;   // next command, pending
    step();                                   // RESP
    for (int i = 0; i < 5; i++) begin
      cmd_valid = i[0];
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_result", 32'(rsp_result), 32'h00);
      chk("bp_flags", 32'(flags()), 32'b010);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      step();
    end
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    step();                                   // handshake edge, cmd_valid also high
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_idle_ready", 32'(cmd_ready), 32'd1);
    chk("bp_idle_valid", 32'(rsp_valid), 32'd0);
    chk("bp_hold_flags", 32'(flags()), 32'b010);
    step();                                   // pending command accepted
    cmd_valid = 1'b0;
    chk("bp_accept_busy", 32'(busy), 32'd1);
    step();
    chk("bp_next_valid", 32'(rsp_valid), 32'd1);
    chk("bp_next_result", 32'(rsp_result), 32'h30);
    chk("bp_next_flags", 32'(flags()), 32'b000);
    step();
    chk("bp_next_done", 32'(rsp_valid), 32'd0);

    // Reset during ORDER of an absolute-difference command.
    cmd_a = 8'h05; cmd_b = 8'h0C; cmd_op = 2'b11;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    step();                                   // accept
    cmd_valid = 1'b0;
    step();                                   // now in ORDER
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_flags", 32'(flags()), 32'b010);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_result", 32'(rsp_result), 32'd0);
    chk("mid_rst_flags", 32'(flags()), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
